// File: rtl/polar_pkg.sv
// Shared constants, CORDIC arctangent table and FSM state type for the
// rectangular-to-polar converter (vector_angle).
package polar_pkg;

    localparam int ITER_COUNT = 12;  // CORDIC micro-rotations, one per cycle
    localparam int ANGLE_BITS = 10;  // output angle: 1024 units per turn
    localparam int ACC_BITS   = 16;  // accumulator: 65536 units per turn
    localparam int IN_BITS    = 10;  // signed input coordinates
    localparam int DP_BITS    = 13;  // X/Y datapath width, headroom for CORDIC gain
    localparam int MAG_BITS   = 11;  // unsigned magnitude output
    localparam int GAIN_RECIP = 622; // 1024 / 1.6468, undoes the CORDIC gain
    localparam int GAIN_SHIFT = 10;

    localparam logic [ACC_BITS-1:0] HALF_TURN   = 16'd32768;
    localparam logic [ACC_BITS-1:0] ANGLE_ROUND = 16'd32;   // half an output LSB
    localparam int                  ANGLE_SHIFT = ACC_BITS - ANGLE_BITS;

    // atan(2^-i) in 65536-per-turn units; entry i sits at index i.
    localparam logic [ITER_COUNT-1:0][ACC_BITS-1:0] ATAN_TABLE = {
        16'd5,   16'd10,  16'd20,   16'd41,   16'd81,   16'd163,
        16'd326, 16'd651, 16'd1297, 16'd2555, 16'd4836, 16'd8192
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i) in
// accumulator units. Indices past the table return zero.
module cordic_atan_rom
    import polar_pkg::*;
(
    input  logic [3:0]          idx,
    output logic [ACC_BITS-1:0] atan
);

    // Table lookup with a zero default for unused indices.
    always_comb begin
        atan = '0;
        if (idx < 4'(ITER_COUNT)) begin
            atan = ATAN_TABLE[idx];
        end
    end

endmodule

// File: rtl/vector_angle.sv
// Rectangular-to-polar converter: iterative CORDIC vectoring, one
// micro-rotation per cycle. angle_o = atan2(y, x) in 1024-per-turn units,
// matching the playfield angle used by the rotator.
// Build option: define POLAR_MAG_EN to add the mag_o port and the
// gain-corrected magnitude path.
module vector_angle
    import polar_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [IN_BITS-1:0] x_i,
    input  logic signed [IN_BITS-1:0] y_i,
    output logic                      busy,
    output logic                      done,
    output logic [ANGLE_BITS-1:0]     angle_o
`ifdef POLAR_MAG_EN
    ,
    output logic [MAG_BITS-1:0]       mag_o
`endif
);

    localparam logic [3:0] LAST_ITER = 4'(ITER_COUNT - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic signed [DP_BITS-1:0] x_r;
    logic signed [DP_BITS-1:0] y_r;
    logic signed [DP_BITS-1:0] x_sh;
    logic signed [DP_BITS-1:0] y_sh;
    logic signed [DP_BITS-1:0] x_nxt;
    logic signed [DP_BITS-1:0] y_nxt;
    logic [ACC_BITS-1:0]       acc_r;
    logic [ACC_BITS-1:0]       acc_nxt;
    logic [ACC_BITS-1:0]       acc_rnd;
    logic [ACC_BITS-1:0]       atan_val;
    logic [ANGLE_BITS-1:0]     angle_nxt;
    logic [3:0]                iter_cnt;
    logic                      zero_r;
    logic                      last_iter;

    cordic_atan_rom u_atan_rom (
        .idx  (iter_cnt),
        .atan (atan_val)
    );

    assign last_iter = (state == ITER) && (iter_cnt == LAST_ITER);
    assign busy      = (state != IDLE);
    assign done      = (state == OUT);

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so requests while busy are dropped.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (last_iter) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One micro-rotation toward y = 0, plus the rounded angle it would produce.
    always_comb begin
        x_sh = x_r >>> iter_cnt;
        y_sh = y_r >>> iter_cnt;
        if (!y_r[DP_BITS-1]) begin
            x_nxt   = x_r + y_sh;
            y_nxt   = y_r - x_sh;
            acc_nxt = acc_r + atan_val;
        end else begin
            x_nxt   = x_r - y_sh;
            y_nxt   = y_r + x_sh;
            acc_nxt = acc_r - atan_val;
        end
        // Wrapping the 16-bit sum makes a full-turn result land on 0, not 1024.
        acc_rnd   = acc_nxt + ANGLE_ROUND;
        angle_nxt = ANGLE_BITS'(acc_rnd >> ANGLE_SHIFT);
    end

`ifdef POLAR_MAG_EN
    localparam int PROD_BITS = DP_BITS + GAIN_SHIFT;

    logic [PROD_BITS-1:0] mag_prod;
    logic [PROD_BITS-1:0] mag_scaled;
    logic [MAG_BITS-1:0]  mag_nxt;

    // Gain correction of the final X, saturated to the output range.
    always_comb begin
        mag_prod   = PROD_BITS'($unsigned(x_nxt)) * PROD_BITS'(GAIN_RECIP);
        mag_scaled = mag_prod >> GAIN_SHIFT;
        if (x_nxt[DP_BITS-1]) begin
            mag_nxt = '0;
        end else if (mag_scaled > PROD_BITS'((1 << MAG_BITS) - 1)) begin
            mag_nxt = '1;
        end else begin
            mag_nxt = MAG_BITS'(mag_scaled);
        end
    end
`endif

    // Datapath: capture on start, fold into the right half-plane, iterate, publish.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well, so an aborted conversion leaves nothing stale behind.
        if (rst) begin
            x_r      <= '0;
            y_r      <= '0;
            acc_r    <= '0;
            iter_cnt <= '0;
            zero_r   <= 1'b0;
            angle_o  <= '0;
`ifdef POLAR_MAG_EN
            mag_o    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r <= {{(DP_BITS-IN_BITS){x_i[IN_BITS-1]}}, x_i};
                        y_r <= {{(DP_BITS-IN_BITS){y_i[IN_BITS-1]}}, y_i};
                    end
                end
                PREP: begin
                    zero_r   <= (x_r == '0) && (y_r == '0);
                    iter_cnt <= '0;
                    // Left half-plane: rotate by a half turn first so CORDIC converges.
                    if (x_r[DP_BITS-1]) begin
                        x_r   <= -x_r;
                        y_r   <= -y_r;
                        acc_r <= HALF_TURN;
                    end else begin
                        acc_r <= '0;
                    end
                end
                ITER: begin
                    x_r      <= x_nxt;
                    y_r      <= y_nxt;
                    acc_r    <= acc_nxt;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (last_iter) begin
                        angle_o <= zero_r ? '0 : angle_nxt;
`ifdef POLAR_MAG_EN
                        mag_o   <= zero_r ? '0 : mag_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_angle.sv
// Self-checking bench for vector_angle: directed axis/diagonal/wrap vectors,
// random vectors against an integer CORDIC reference model, ignored starts,
// back-to-back conversions and reset abort. Mag checks are compiled in only
// when POLAR_MAG_EN is defined.
`timescale 1ns/1ps
module tb_vector_angle;

    localparam int ATAN_REF [12] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5};
    localparam real PI = 3.14159265358979;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [9:0] x_i;
    logic signed [9:0] y_i;
    logic              busy;
    logic              done;
    logic [9:0]        angle_o;
`ifdef POLAR_MAG_EN
    logic [10:0]       mag_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_angle dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x_i     (x_i),
        .y_i     (y_i),
        .busy    (busy),
        .done    (done),
        .angle_o (angle_o)
`ifdef POLAR_MAG_EN
        ,
        .mag_o   (mag_o)
`endif
    );

    // Reference: the vectoring algorithm as plain integer arithmetic.
    function automatic void model(input int x, input int y, output int ang, output int mag);
        int xs, ys, acc, nx, ny;
        if (x == 0 && y == 0) begin
            ang = 0;
            mag = 0;
            return;
        end
        xs  = x;
        ys  = y;
        acc = 0;
        if (xs < 0) begin
            xs  = -xs;
            ys  = -ys;
            acc = 32768;
        end
        for (int i = 0; i < 12; i++) begin
            if (ys >= 0) begin
                nx  = xs + (ys >>> i);
                ny  = ys - (xs >>> i);
                acc = acc + ATAN_REF[i];
            end else begin
                nx  = xs - (ys >>> i);
                ny  = ys + (xs >>> i);
                acc = acc - ATAN_REF[i];
            end
            xs = nx;
            ys = ny;
        end
        acc = acc & 65535;
        ang = ((acc + 32) >> 6) & 1023;
        mag = (xs * 622) >> 10;
        if (mag > 2047) mag = 2047;
    endfunction

    function automatic int ideal_angle(input int x, input int y);
        real r;
        r = $atan2(real'(y), real'(x)) * 1024.0 / (2.0 * PI);
        if (r < 0.0) r = r + 1024.0;
        return int'(r) % 1024;
    endfunction

    function automatic int circ_diff(input int a, input int b);
        int d;
        d = (((a - b) % 1024) + 1024) % 1024;
        return (d > 512) ? 1024 - d : d;
    endfunction

    // Drives one request and follows it to done. lat=-1 on timeout.
    // poke_done raises start (with other inputs) during the done cycle.
    task automatic convert(input int x, input int y, input bit poke_done,
                           output int lat, output int ang, output int mag,
                           output bit busy_ok, output bit busy_after, output bit done_after);
        lat     = -1;
        ang     = -1;
        mag     = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        x_i   = 10'(x);
        y_i   = 10'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                ang = int'(angle_o);
`ifdef POLAR_MAG_EN
                mag = int'(mag_o);
`endif
                break;
            end
            @(posedge clk);
            #1;
        end
        if (poke_done) begin
            x_i   = 10'(x + 37);
            y_i   = 10'(y - 91);
            start = 1'b1;
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        x_i   = 10'sd5;
        y_i   = 10'sd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || angle_o !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b angle=%0d expected 0 0 0", busy, done, angle_o);
        end
`ifdef POLAR_MAG_EN
        checks++;
        if (mag_o !== 11'd0) begin
            failures++;
            $display("FAIL reset_mag: got %0d expected 0", mag_o);
        end
`endif
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        int dx [9] = '{100, 0, -100, 0, -512, 100, 0, -1, 511};
        int dy [9] = '{0, 100, 0, -100, -512, -1, 0, -1, -512};
        int lat, ang, mag, eang, emag;
        bit bok, bafter, dafter;
        for (int i = 0; i < 9; i++) begin
            model(dx[i], dy[i], eang, emag);
            convert(dx[i], dy[i], 1'b0, lat, ang, mag, bok, bafter, dafter);
            checks++;
            if (lat !== 14) begin
                failures++;
                $display("FAIL dir_latency(%0d,%0d): got %0d expected 14", dx[i], dy[i], lat);
            end
            checks++;
            if (ang !== eang) begin
                failures++;
                $display("FAIL dir_angle(%0d,%0d): got %0d expected %0d", dx[i], dy[i], ang, eang);
            end
            checks++;
            if (bok !== 1'b1 || bafter !== 1'b0 || dafter !== 1'b0) begin
                failures++;
                $display("FAIL dir_busy(%0d,%0d): during=%b after=%b done_after=%b expected 1 0 0",
                         dx[i], dy[i], bok, bafter, dafter);
            end
            if (i < 5) begin
                checks++;
                if (circ_diff(ang, ideal_angle(dx[i], dy[i])) > 1) begin
                    failures++;
                    $display("FAIL dir_ideal_angle(%0d,%0d): got %0d expected %0d +/-1",
                             dx[i], dy[i], ang, ideal_angle(dx[i], dy[i]));
                end
            end
            if (i == 5 || i == 6) begin
                checks++;
                if (ang !== 0) begin
                    failures++;
                    $display("FAIL dir_wrap_zero(%0d,%0d): got %0d expected 0", dx[i], dy[i], ang);
                end
            end
`ifdef POLAR_MAG_EN
            checks++;
            if (mag !== emag) begin
                failures++;
                $display("FAIL dir_mag(%0d,%0d): got %0d expected %0d", dx[i], dy[i], mag, emag);
            end
            if (i < 5) begin
                checks++;
                if ((mag - int'($sqrt(real'(dx[i]*dx[i] + dy[i]*dy[i])) + 0.5)) > 2 ||
                    (int'($sqrt(real'(dx[i]*dx[i] + dy[i]*dy[i])) + 0.5) - mag) > 2) begin
                    failures++;
                    $display("FAIL dir_ideal_mag(%0d,%0d): got %0d expected %0d +/-2", dx[i], dy[i], mag,
                             int'($sqrt(real'(dx[i]*dx[i] + dy[i]*dy[i])) + 0.5));
                end
            end
`endif
        end
    endtask

    task automatic test_random();
        int lat, ang, mag, eang, emag, x, y;
        bit bok, bafter, dafter;
        logic signed [9:0] rx, ry;
        for (int i = 0; i < 40; i++) begin
            rx = 10'($urandom);
            ry = 10'($urandom);
            x  = int'(rx);
            y  = int'(ry);
            model(x, y, eang, emag);
            convert(x, y, 1'b0, lat, ang, mag, bok, bafter, dafter);
            checks++;
            if (lat !== 14 || ang !== eang) begin
                failures++;
                $display("FAIL rand(%0d,%0d): latency=%0d angle=%0d expected 14 %0d", x, y, lat, ang, eang);
            end
`ifdef POLAR_MAG_EN
            checks++;
            if (mag !== emag) begin
                failures++;
                $display("FAIL rand_mag(%0d,%0d): got %0d expected %0d", x, y, mag, emag);
            end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int lat, ang, mag, eang, emag, extra;
        model(-300, 200, eang, emag);
        lat = -1;
        ang = -1;
        mag = -1;
        @(negedge clk);
        x_i   = -10'sd300;
        y_i   = 10'sd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 40; n++) begin
            if (done === 1'b1) begin
                lat = n;
                ang = int'(angle_o);
`ifdef POLAR_MAG_EN
                mag = int'(mag_o);
`endif
                break;
            end
            start = (n == 3 || n == 10);
            x_i   = 10'($urandom);
            y_i   = 10'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (lat !== 14 || ang !== eang) begin
            failures++;
            $display("FAIL ignore_first_result: latency=%0d angle=%0d expected 14 %0d", lat, ang, eang);
        end
`ifdef POLAR_MAG_EN
        checks++;
        if (mag !== emag) begin
            failures++;
            $display("FAIL ignore_first_mag: got %0d expected %0d", mag, emag);
        end
`endif
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ignore_no_queue: extra done pulses %0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ang, mag, eang, emag, held;
        bit bok, bafter, dafter;
        model(250, 400, eang, emag);
        convert(250, 400, 1'b1, lat, ang, mag, bok, bafter, dafter);
        checks++;
        if (lat !== 14 || ang !== eang) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d angle=%0d expected 14 %0d", lat, ang, eang);
        end
        checks++;
        if (bafter !== 1'b0 || dafter !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_cycle_start: busy=%b done=%b expected 0 0", bafter, dafter);
        end
        held = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (int'(angle_o) !== eang || busy !== 1'b0) held = 0;
        end
        checks++;
        if (held !== 1) begin
            failures++;
            $display("FAIL b2b_hold: angle=%0d busy=%b expected %0d 0", angle_o, busy, eang);
        end
        for (int k = 0; k < 3; k++) begin
            model(-17 * (k + 1), 123 - 100 * k, eang, emag);
            convert(-17 * (k + 1), 123 - 100 * k, 1'b0, lat, ang, mag, bok, bafter, dafter);
            checks++;
            if (lat !== 14 || ang !== eang || bok !== 1'b1) begin
                failures++;
                $display("FAIL b2b_run%0d: latency=%0d angle=%0d busy_ok=%b expected 14 %0d 1",
                         k, lat, ang, bok, eang);
            end
        end
    endtask

    task automatic test_rst_abort();
        int lat, ang, mag, eang, emag, seen;
        bit bok, bafter, dafter;
        @(negedge clk);
        x_i   = 10'sd321;
        y_i   = -10'sd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        x_i   = 10'sd9;
        y_i   = 10'sd9;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || angle_o !== 10'd0) begin
            failures++;
            $display("FAIL abort_outputs: busy=%b done=%b angle=%0d expected 0 0 0", busy, done, angle_o);
        end
`ifdef POLAR_MAG_EN
        checks++;
        if (mag_o !== 11'd0) begin
            failures++;
            $display("FAIL abort_mag: got %0d expected 0", mag_o);
        end
`endif
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        seen  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_quiet: busy/done cycles %0d expected 0", seen);
        end
        model(-200, -350, eang, emag);
        convert(-200, -350, 1'b0, lat, ang, mag, bok, bafter, dafter);
        checks++;
        if (lat !== 14 || ang !== eang) begin
            failures++;
            $display("FAIL abort_restart: latency=%0d angle=%0d expected 14 %0d", lat, ang, eang);
        end
`ifdef POLAR_MAG_EN
        checks++;
        if (mag !== emag) begin
            failures++;
            $display("FAIL abort_restart_mag: got %0d expected %0d", mag, emag);
        end
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x_i   = '0;
        y_i   = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
